// File: rtl/riscy_core_gen2.sv
// riscy_core_gen2: 4-phase RISC_Y core with A/B/ACC datapath, ALU flags, PC and split I/O channels.
// Optional build macro RISCY_PORT_STALL_EN adds PORT_VALID and stalls IN/OUT in EXECUTE until the channel is valid.
module riscy_core_gen2 #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int PORTS  = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   output logic [ADDR_W-1:0]       ROM_ADDR,
   input  logic [ADDR_W+4:0]       ROM_DATA,
   output logic [ADDR_W-1:0]       RAM_ADDR,
   input  logic [DATA_W-1:0]       RAM_RDATA,
   output logic [DATA_W-1:0]       RAM_WDATA,
   output logic                    RAM_WE,
   input  logic [PORTS*DATA_W-1:0] PORT_IN,
`ifdef RISCY_PORT_STALL_EN
   input  logic [PORTS-1:0]        PORT_VALID,
`endif
   output logic [PORTS*DATA_W-1:0] PORT_OUT,
   output logic [PORTS-1:0]        PORT_WR,
   output logic [1:0]              PHASE,
   output logic [3:0]              FLAGS,
   output logic                    HALTED
);
   localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

   localparam logic [3:0] OP_LDA = 4'h1, OP_LDB = 4'h2, OP_STO = 4'h3, OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB, OP_JC  = 4'hC;
   localparam logic [3:0] OP_IN  = 4'hD, OP_OUT = 4'hE, OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      PH_FETCH     = 2'd0,
      PH_DECODE    = 2'd1,
      PH_EXECUTE   = 2'd2,
      PH_WRITEBACK = 2'd3
   } phase_t;

   phase_t                  phase_r, phase_nxt_s;
   logic [ADDR_W+4:0]       ir_r;
   logic [ADDR_W-1:0]       pc_r;
   logic [DATA_W-1:0]       a_r, b_r, acc_r;
   logic [3:0]              flags_r;
   logic [PORTS*DATA_W-1:0] port_out_r;
   logic [PORTS-1:0]        port_wr_r;
   logic                    ram_we_r, halted_r;

   logic [3:0]        opcode_s;
   logic              i_flag_s;
   logic [ADDR_W-1:0] operand_s;
   logic [SEL_W-1:0]  sel_s;
   logic              sel_ok_s, io_op_s, io_ready_s, stall_s, exec_s, jump_s;
   logic [DATA_W-1:0] opv_s, port_in_sel_s, alu_res_s;
   logic [DATA_W:0]   sum_s;
   logic              alu_cf_s, alu_of_s;

   assign opcode_s      = ir_r[ADDR_W+4:ADDR_W+1];
   assign i_flag_s      = ir_r[ADDR_W];
   assign operand_s     = ir_r[ADDR_W-1:0];
   assign sel_s         = operand_s[SEL_W-1:0];
   assign sel_ok_s      = (int'(sel_s) < PORTS);
   assign io_op_s       = (opcode_s == OP_IN) || (opcode_s == OP_OUT);
   assign opv_s         = i_flag_s ? operand_s[DATA_W-1:0] : RAM_RDATA;
   assign port_in_sel_s = PORT_IN[int'(sel_s)*DATA_W +: DATA_W];

`ifdef RISCY_PORT_STALL_EN
   assign io_ready_s = PORT_VALID[sel_s];
`else
   assign io_ready_s = 1'b1;
`endif

   // An I/O op on a valid channel without a ready handshake holds the core in EXECUTE
   assign stall_s = (phase_r == PH_EXECUTE) && io_op_s && sel_ok_s && !io_ready_s;
   assign exec_s  = (phase_r == PH_EXECUTE) && !stall_s;
   // Jump conditions see flags as left by EXECUTE, since WRITEBACK follows it
   assign jump_s  = (opcode_s == OP_JMP) || ((opcode_s == OP_JZ) && flags_r[1]) ||
                    ((opcode_s == OP_JC) && flags_r[0]);

   // ALU result, carry/borrow and signed overflow for opcodes 4-9
   always_comb begin
      sum_s     = {(DATA_W+1){1'b0}};
      alu_res_s = {DATA_W{1'b0}};
      alu_cf_s  = 1'b0;
      alu_of_s  = 1'b0;
      case (opcode_s)
         OP_ADD: begin
            sum_s     = {1'b0, a_r} + {1'b0, b_r};
            alu_res_s = sum_s[DATA_W-1:0];
            alu_cf_s  = sum_s[DATA_W];
            alu_of_s  = (a_r[DATA_W-1] == b_r[DATA_W-1]) && (alu_res_s[DATA_W-1] != a_r[DATA_W-1]);
         end
         OP_SUB: begin
            sum_s     = {1'b0, a_r} - {1'b0, b_r};
            alu_res_s = sum_s[DATA_W-1:0];
            alu_cf_s  = sum_s[DATA_W];
            alu_of_s  = (a_r[DATA_W-1] != b_r[DATA_W-1]) && (alu_res_s[DATA_W-1] != a_r[DATA_W-1]);
         end
         OP_AND:  alu_res_s = a_r & b_r;
         OP_OR:   alu_res_s = a_r | b_r;
         OP_XOR:  alu_res_s = a_r ^ b_r;
         OP_NOT:  alu_res_s = ~a_r;
         default: alu_res_s = {DATA_W{1'b0}};
      endcase
   end

   // Phase sequencing: one cycle per phase, stall in EXECUTE, park in WRITEBACK when halted
   always_comb begin
      phase_nxt_s = PH_FETCH;
      case (phase_r)
         PH_FETCH:     phase_nxt_s = PH_DECODE;
         PH_DECODE:    phase_nxt_s = PH_EXECUTE;
         PH_EXECUTE:   phase_nxt_s = stall_s ? PH_EXECUTE : PH_WRITEBACK;
         PH_WRITEBACK: phase_nxt_s = halted_r ? PH_WRITEBACK : PH_FETCH;
         default:      phase_nxt_s = PH_FETCH;
      endcase
   end

   // Phase state register
   always_ff @(posedge CLK) begin
      if (RST) phase_r <= PH_FETCH;
      else     phase_r <= phase_nxt_s;
   end

   // Datapath, PC and registered strobes
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_r       <= {ADDR_W{1'b0}};
         ir_r       <= {(ADDR_W+5){1'b0}};
         a_r        <= {DATA_W{1'b0}};
         b_r        <= {DATA_W{1'b0}};
         acc_r      <= {DATA_W{1'b0}};
         flags_r    <= 4'b0000;
         port_out_r <= {(PORTS*DATA_W){1'b0}};
         port_wr_r  <= {PORTS{1'b0}};
         ram_we_r   <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         ram_we_r  <= 1'b0;
         port_wr_r <= {PORTS{1'b0}};
         if (phase_r == PH_FETCH) ir_r <= ROM_DATA;
         if (exec_s) begin
            case (opcode_s)
               OP_LDA: a_r <= opv_s;
               OP_LDB: b_r <= opv_s;
               OP_STO: ram_we_r <= ~i_flag_s;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                  acc_r   <= alu_res_s;
                  flags_r <= {alu_of_s, alu_res_s[DATA_W-1],
                              (alu_res_s == {DATA_W{1'b0}}), alu_cf_s};
               end
               OP_IN:  if (sel_ok_s) a_r <= port_in_sel_s;
               OP_OUT: if (sel_ok_s) begin
                  port_out_r[int'(sel_s)*DATA_W +: DATA_W] <= acc_r;
                  port_wr_r[sel_s]                         <= 1'b1;
               end
               OP_HALT: halted_r <= 1'b1;
               default: ;
            endcase
         end
         if ((phase_r == PH_WRITEBACK) && !halted_r)
            pc_r <= jump_s ? operand_s : pc_r + PC_STEP;
      end
   end

   assign ROM_ADDR  = pc_r;
   assign RAM_ADDR  = operand_s;
   assign RAM_WDATA = acc_r;
   assign RAM_WE    = ram_we_r;
   assign PORT_OUT  = port_out_r;
   assign PORT_WR   = port_wr_r;
   assign PHASE     = phase_r;
   assign FLAGS     = flags_r;
   assign HALTED    = halted_r;
endmodule
